mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Load/store unit for the MEM stage of the five-stage pipeline. It takes the memory operation latched in the EX/MEM register and runs it against a data memory with a request/grant/response handshake. It holds the pipeline with `stall` while a transaction is outstanding, and delivers sign- or zero-extended load data to the MEM/WB register. It replaces the single-cycle combinational data-memory access in the MEM stage.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, data width; fixed at 32 (4 byte lanes).

Ports. One clock; reset is asynchronous and active-low.
- `clock`  in  1  pipeline clock; all state is updated on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `ex_valid`  in  1  EX/MEM holds a valid instruction.
- `ex_mem_read`  in  1  instruction is a load.
- `ex_mem_write`  in  1  instruction is a store.
- `ex_size`  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is illegal and treated as misaligned.
- `ex_unsigned`  in  1  zero-extend the load (lbu/lhu).
- `ex_addr`  in  ADDR_W  byte address (the ALU result).
- `ex_wdata`  in  32  store data (the second register read).
- `stall`  out  1  freeze the PC, IF/ID, ID/EX and EX/MEM registers.
- `wb_valid`  out  1  one-cycle pulse: load data is valid.
- `wb_rdata`  out  32  extended load data.
- `misalign_err`  out  1  one-cycle pulse: access rejected.
- `mem_req`  out  1  request to data memory.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  ADDR_W  word-aligned address (`[1:0]` = 0).
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-steered store data.
- `mem_gnt`  in  1  memory accepted the request.
- `mem_rvalid`  in  1  response (read data, or write acknowledge).
- `mem_rdata`  in  32  read word.

## Operation
- States: IDLE, REQ, RESP.
- **Accept:** in IDLE, accept when `ex_valid & (ex_mem_read | ex_mem_write)`.
  - If both read and write are set, the read wins.
- **Alignment:** a half access requires `addr[0] = 0`; a word access requires `addr[1:0] = 0`.
  - A misaligned or size-3 access issues no request and does not stall.
  - `misalign_err` pulses in the next cycle and the FSM stays in IDLE.
- **Aligned accept:** latch the request fields and go to REQ.
- **REQ:** `mem_req = 1` with stable `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` until `mem_gnt`.
  - On `mem_gnt` alone, go to RESP.
  - On `mem_gnt & mem_rvalid` in the same cycle, complete immediately and go to IDLE.
- **RESP:** `mem_req = 0`; wait for `mem_rvalid`, then go to IDLE.
- **Completion:** a load pulses `wb_valid` one cycle after the `mem_rvalid` cycle. A store completes silently.
- **Lanes (little-endian):** `lane = addr[1:0]`.
  - Byte: `be = 1 << lane`; write data is the byte replicated ×4.
  - Half: `be = 0011` or `1100`; write data is the half replicated ×2.
  - Word: `be = 1111`.
- **Load extension:** select the byte or half at the lane, then sign-extend from bit 7 or bit 15 unless `ex_unsigned`. Words pass through unchanged.
- **Stray responses:** `mem_rvalid` or `mem_gnt` seen in IDLE is ignored.

## Timing
- `stall = (state != IDLE) | aligned_accept`.
  - It is combinational and high in the accept cycle.
  - It stays high through the cycle in which `mem_rvalid` is seen, inclusive, and is low in the following cycle.
- **Load latency:** with grant and response each arriving one cycle after request, the sequence is:
  - accept at t0;
  - `mem_req` and `mem_gnt` at t1;
  - `mem_rvalid` at t2;
  - `wb_valid` at t3.
- **Minimum latency:** with gnt and rvalid both arriving at t1, `wb_valid` is at t2.
- `mem_req` is registered: it rises in the cycle after accept and deasserts in the cycle after `mem_gnt`.
- `wb_rdata` is registered and holds its value until the next load completes.
- **Reset values:** all outputs are 0 and the state is IDLE.
- **Reset mid-transaction:** `mem_req` drops asynchronously and no `wb_valid` is produced.
  - A response arriving after reset is ignored.
- **Back-to-back accesses:** a new access is accepted in the first cycle `stall` is low. No bubble is required beyond that cycle.

## Structure
- Shared package `mips_pkg` holds:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the `lsu_state_t` enum (IDLE, REQ, RESP).
- One combinational sub-module, `lsu_align`:
  - store lane steering and byte-enable generation;
  - load lane select and extension;
  - misalignment detection.
- The FSM and the registered outputs live in `mem_stage_lsu`.

## Test plan
- **lb, sign-extended:** `addr = 0x103`, rdata = `0x80FF_FF7F`, gnt at t1, rvalid at t2 -> `mem_addr = 0x100`, `be = 1000`, `wb_rdata = 0xFFFF_FF80` at t3, `stall` high t0–t2.
- **lhu:** `addr = 0x202`, rdata = `0x9ABC_1234` -> `be = 1100`, `wb_rdata = 0x0000_9ABC`.
- **sb:** `addr = 0x301`, wdata = `0x1122_33AA`, gnt held low 3 cycles -> `mem_req` stays high with stable `be = 0010` and `mem_wdata = 0xAAAA_AAAA`; `stall` is released the cycle after the write ack; no `wb_valid`.
- **Misaligned lw:** `addr = 0x402` -> no `mem_req`, `stall` never high, `misalign_err` pulses at t1.
- **Zero-latency load:** gnt and rvalid both at t1 with rdata = `0xDEAD_BEEF` (lw) -> `wb_rdata = 0xDEAD_BEEF` at t2; a second lw accepted at t2 completes normally.
- **Reset in RESP:** assert `reset_n = 0` in RESP, then deliver rvalid after release -> `mem_req` = 0, `stall` = 0, no `wb_valid`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared pipeline definitions: access-size encodings and the load/store unit state type.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/grant/response bus. master = load/store unit, slave = memory.
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane logic for the load/store unit: store steering, byte enables, misalignment
// detection and load lane select/extension. Purely combinational, no handshake.
module lsu_align
  import mips_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_lane,
  output logic        misaligned,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be         = 4'b0000;
    st_wdata_lane = 32'h0;
    misaligned    = 1'b1;
    case (st_size)
      SZ_BYTE: begin
        st_be         = 4'b0001 << st_lane;
        st_wdata_lane = {4{st_wdata[7:0]}};
        misaligned    = 1'b0;
      end
      SZ_HALF: begin
        st_be         = st_lane[1] ? 4'b1100 : 4'b0011;
        st_wdata_lane = {2{st_wdata[15:0]}};
        misaligned    = st_lane[0];
      end
      SZ_WORD: begin
        st_be         = 4'b1111;
        st_wdata_lane = st_wdata;
        misaligned    = |st_lane;
      end
      default: begin
        st_be         = 4'b0000;
        st_wdata_lane = 32'h0;
        misaligned    = 1'b1;
      end
    endcase
  end

  always_comb begin
    ld_byte = ld_rdata[{ld_lane, 3'b000} +: 8];
    ld_half = ld_lane[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_size)
      SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one access at a time over req/gnt/rvalid; load data one cycle after rvalid.
// Stalls the pipeline from the accept cycle through the rvalid cycle; misaligned accesses never stall.
module mem_stage_lsu
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_rdata,
  output logic              misalign_err,
  mem_stage_lsu_if.master   mem
);

  lsu_state_t        state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        ld_size_q;
  logic [1:0]        ld_lane_q;
  logic              ld_uns_q;
  logic              wb_valid_q;
  logic [DATA_W-1:0] wb_rdata_q;
  logic              misalign_q;

  logic              accept;
  logic              aligned_accept;
  logic              complete;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata_lane;
  logic              misaligned;
  logic [DATA_W-1:0] ld_data;

  lsu_align u_align (
    .st_size       (ex_size),
    .st_lane       (ex_addr[1:0]),
    .st_wdata      (ex_wdata),
    .st_be         (st_be),
    .st_wdata_lane (st_wdata_lane),
    .misaligned    (misaligned),
    .ld_size       (ld_size_q),
    .ld_lane       (ld_lane_q),
    .ld_unsigned   (ld_uns_q),
    .ld_rdata      (mem.mem_rdata),
    .ld_data       (ld_data)
  );

  assign accept         = (state_q == IDLE) & ex_valid & (ex_mem_read | ex_mem_write);
  assign aligned_accept = accept & ~misaligned;
  assign complete       = ((state_q == REQ) & mem.mem_gnt & mem.mem_rvalid) |
                          ((state_q == RESP) & mem.mem_rvalid);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= '0;
      ld_size_q  <= SZ_BYTE;
      ld_lane_q  <= 2'b00;
      ld_uns_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rdata_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      misalign_q <= accept & misaligned;
      case (state_q)
        IDLE: begin
          // Read wins when both read and write are flagged.
          if (aligned_accept) begin
            state_q   <= REQ;
            we_q      <= ~ex_mem_read;
            addr_q    <= {ex_addr[ADDR_W-1:2], 2'b00};
            be_q      <= st_be;
            wdata_q   <= st_wdata_lane;
            ld_size_q <= ex_size;
            ld_lane_q <= ex_addr[1:0];
            ld_uns_q  <= ex_unsigned;
          end
        end
        REQ: begin
          if (mem.mem_gnt) begin
            state_q <= mem.mem_rvalid ? IDLE : RESP;
          end
        end
        RESP: begin
          if (mem.mem_rvalid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (complete && !we_q) begin
        wb_valid_q <= 1'b1;
        wb_rdata_q <= ld_data;
      end
    end
  end

  assign stall         = (state_q != IDLE) | aligned_accept;
  assign wb_valid      = wb_valid_q;
  assign wb_rdata      = wb_rdata_q;
  assign misalign_err  = misalign_q;
  assign mem.mem_req   = (state_q == REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed cases plus randomized accesses against a lane-arithmetic model.
module tb_mem_stage_lsu;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ex_valid;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_rdata;
  logic        misalign_err;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_last = 32'h0;

  mem_stage_lsu_if #(.ADDR_W(32)) mem_if ();

  mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_size      (ex_size),
    .ex_unsigned  (ex_unsigned),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_rdata     (wb_rdata),
    .misalign_err (misalign_err),
    .mem          (mem_if)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic mis_f(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [3:0] be_f(input logic [1:0] sz, input logic [31:0] a);
    int lane = int'(a[1:0]);
    if (sz == 2'd0) return 4'(1 << lane);
    if (sz == 2'd1) return 4'(3 << lane);
    return 4'hF;
  endfunction

  function automatic logic [31:0] wdata_f(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return 32'(wd[7:0]) * 32'h0101_0101;
    if (sz == 2'd1) return 32'(wd[15:0]) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] load_f(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] rd);
    int          lane = int'(a[1:0]);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * lane)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (8 * lane)) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // gd: request cycles before grant; rvd: cycles from grant to response (0 = same cycle).
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int gd, input int rvd, input logic [31:0] rdat);
    logic mis;
    logic acc;
    mis = mis_f(sz, a);
    acc = rd | wr;
    ex_valid     = 1'b1;
    ex_mem_read  = rd;
    ex_mem_write = wr;
    ex_size      = sz;
    ex_unsigned  = uns;
    ex_addr      = a;
    ex_wdata     = wd;
    mem_if.mem_gnt    = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    #1;
    check("accept_stall", stall, acc && !mis);
    check("accept_req", mem_if.mem_req, 1'b0);
    step();
    if (!acc || mis) begin
      ex_valid = 1'b0;
      #1;
      check("misalign_err", misalign_err, acc && mis);
      check("noreq_req", mem_if.mem_req, 1'b0);
      check("noreq_stall", stall, 1'b0);
      check("noreq_wb_valid", wb_valid, 1'b0);
      check("noreq_wb_rdata", wb_rdata, exp_last);
      return;
    end
    check("aligned_no_err", misalign_err, 1'b0);
    for (int k = 0; k <= gd; k++) begin
      check("req_high", mem_if.mem_req, 1'b1);
      check("req_we", mem_if.mem_we, !rd);
      check("req_addr", mem_if.mem_addr, a & 32'hFFFF_FFFC);
      check("req_be", mem_if.mem_be, be_f(sz, a));
      check("req_wdata", mem_if.mem_wdata, wdata_f(sz, wd));
      mem_if.mem_gnt    = (k == gd);
      mem_if.mem_rvalid = (k == gd) && (rvd == 0);
      mem_if.mem_rdata  = rdat;
      #1;
      check("req_stall", stall, 1'b1);
      check("req_wb_valid", wb_valid, 1'b0);
      step();
    end
    mem_if.mem_gnt    = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    for (int j = 1; j <= rvd; j++) begin
      check("resp_req_low", mem_if.mem_req, 1'b0);
      mem_if.mem_rvalid = (j == rvd);
      mem_if.mem_rdata  = rdat;
      #1;
      check("resp_stall", stall, 1'b1);
      step();
    end
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = $urandom;
    ex_valid          = 1'b0;
    #1;
    check("done_stall", stall, 1'b0);
    check("done_req", mem_if.mem_req, 1'b0);
    check("done_wb_valid", wb_valid, rd);
    if (rd) exp_last = load_f(sz, uns, a, rdat);
    check("done_wb_rdata", wb_rdata, exp_last);
  endtask

  task automatic idle_stray();
    ex_valid          = $urandom_range(0, 1);
    ex_mem_read       = 1'b0;
    ex_mem_write      = 1'b0;
    mem_if.mem_gnt    = $urandom_range(0, 1);
    mem_if.mem_rvalid = $urandom_range(0, 1);
    mem_if.mem_rdata  = $urandom;
    #1;
    check("idle_stall", stall, 1'b0);
    check("idle_req", mem_if.mem_req, 1'b0);
    step();
    mem_if.mem_gnt    = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    ex_valid          = 1'b0;
    #1;
    check("idle_wb_valid", wb_valid, 1'b0);
    check("idle_misalign", misalign_err, 1'b0);
    check("idle_wb_rdata", wb_rdata, exp_last);
  endtask

  initial begin
    reset_n           = 1'b0;
    ex_valid          = 1'b0;
    ex_mem_read       = 1'b0;
    ex_mem_write      = 1'b0;
    ex_size           = 2'd0;
    ex_unsigned       = 1'b0;
    ex_addr           = 32'h0;
    ex_wdata          = 32'h0;
    mem_if.mem_gnt    = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = 32'h0;
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_rdata", wb_rdata, 32'h0);
    check("rst_misalign", misalign_err, 1'b0);
    check("rst_req", mem_if.mem_req, 1'b0);
    check("rst_we", mem_if.mem_we, 1'b0);
    check("rst_addr", mem_if.mem_addr, 32'h0);
    check("rst_be", {28'h0, mem_if.mem_be}, 32'h0);
    check("rst_wdata", mem_if.mem_wdata, 32'h0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // lb sign-extended, lhu, sb with slow grant, misaligned lw, zero-latency lw pair
    run_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 0, 1, 32'h80FF_FF7F);
    check("lb_value", wb_rdata, 32'hFFFF_FF80);
    run_op(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0202, 32'h0, 0, 1, 32'h9ABC_1234);
    check("lhu_value", wb_rdata, 32'h0000_9ABC);
    run_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0301, 32'h1122_33AA, 3, 1, 32'h0);
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0402, 32'h0, 0, 1, 32'h0);
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0, 0, 0, 32'hDEAD_BEEF);
    check("lw_zero_lat", wb_rdata, 32'hDEAD_BEEF);
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0504, 32'h0, 1, 2, 32'h1234_5678);
    run_op(1'b1, 1'b1, 2'd1, 1'b0, 32'h0000_0606, 32'h5555_AAAA, 0, 1, 32'h8001_0000);
    run_op(1'b0, 1'b1, 2'd3, 1'b0, 32'h0000_0700, 32'h0, 0, 1, 32'h0);

    // reset while waiting for the response
    ex_valid     = 1'b1;
    ex_mem_read  = 1'b1;
    ex_mem_write = 1'b0;
    ex_size      = 2'd2;
    ex_unsigned  = 1'b0;
    ex_addr      = 32'h0000_0800;
    step();
    mem_if.mem_gnt = 1'b1;
    step();
    mem_if.mem_gnt = 1'b0;
    #1;
    check("resp_state_stall", stall, 1'b1);
    ex_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("arst_req", mem_if.mem_req, 1'b0);
    check("arst_stall", stall, 1'b0);
    check("arst_wb_rdata", wb_rdata, 32'h0);
    exp_last = 32'h0;
    step();
    reset_n = 1'b1;
    step();
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 32'hCAFE_F00D;
    #1;
    check("late_rv_stall", stall, 1'b0);
    step();
    mem_if.mem_rvalid = 1'b0;
    #1;
    check("late_rv_wb_valid", wb_valid, 1'b0);
    check("late_rv_req", mem_if.mem_req, 1'b0);
    check("late_rv_wb_rdata", wb_rdata, exp_last);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle_stray();
      end else begin
        logic [31:0] ra;
        ra = $urandom;
        if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
        run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ra, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
